// File: rtl/timer_arbiter.sv
// Round-robin arbiter that time-shares a single Timer between N_REQ requesters.
// Each session: grant, clear timer, enable with latched config, wait for completion, release.
module timer_arbiter #(
  parameter int N_REQ     = 4,
  parameter int PERIOD_W  = 32,
  parameter int TIMEOUT_W = 24
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_REQ-1:0]          i_Req,
  input  logic [N_REQ*PERIOD_W-1:0] i_ReqPeriod,
  input  logic [N_REQ*2-1:0]        i_ReqMode,
  input  logic [N_REQ*2-1:0]        i_ReqDivisor,
  output logic [N_REQ-1:0]          o_Grant,
  output logic [N_REQ-1:0]          o_Done,
  output logic                      o_Timeout,
  output logic                      o_Busy,
  output logic [PERIOD_W-1:0]       o_TimPeriod,
  output logic [1:0]                o_TimMode,
  output logic [1:0]                o_TimDivisor,
  output logic                      o_TimEnable,
  output logic                      o_TimAutoReload,
  output logic                      o_TimRst,
  input  logic                      i_TimOverflow,
  input  logic                      i_TimOnePulse
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_ARM     = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  localparam logic [1:0] M_TIMER   = 2'b00;
  localparam logic [1:0] M_ONEPULS = 2'b11;

  logic [2:0]           r_state;
  logic [IDX_W-1:0]     r_owner;
  logic [IDX_W-1:0]     r_last;
  logic [PERIOD_W-1:0]  r_period;
  logic [1:0]           r_mode;
  logic [1:0]           r_div;
  logic [TIMEOUT_W-1:0] r_wdog;
  logic                 r_ovf_s1, r_ovf_s2;
  logic                 r_pul_s1, r_pul_s2;
  logic                 r_pulse_seen;
  logic                 r_done_flag;
  logic                 r_to_flag;

  logic [IDX_W-1:0]     w_win;
  logic [IDX_W-1:0]     w_cand;
  logic [N_REQ-1:0]     w_owner_oh;
  logic [TIMEOUT_W-1:0] w_wdog_nxt;
  logic                 w_owner_req;
  logic                 w_held_mode;
  logic                 w_abort;
  logic                 w_finish;
  logic                 w_wd_expire;

  // Descending scan so the smallest offset from last-grant wins.
  always_comb begin
    w_win  = r_last;
    w_cand = r_last;
    for (int i = N_REQ; i >= 1; i--) begin
      w_cand = IDX_W'((int'(r_last) + i) % N_REQ);
      if (i_Req[w_cand]) w_win = w_cand;
    end
  end

  always_comb begin
    w_owner_oh          = '0;
    w_owner_oh[r_owner] = 1'b1;
  end

  assign w_owner_req = i_Req[r_owner];
  assign w_held_mode = (r_mode != M_TIMER) && (r_mode != M_ONEPULS);
  assign w_wdog_nxt  = r_wdog + 1'b1;
  assign w_wd_expire = &w_wdog_nxt;
  assign w_abort     = !w_held_mode && !w_owner_req;
  assign w_finish    = ((r_mode == M_TIMER)   && r_ovf_s2) ||
                       ((r_mode == M_ONEPULS) && r_pulse_seen && !r_pul_s2) ||
                       (w_held_mode && !w_owner_req);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovf_s1 <= 1'b0;
      r_ovf_s2 <= 1'b0;
      r_pul_s1 <= 1'b0;
      r_pul_s2 <= 1'b0;
    end else begin
      r_ovf_s1 <= i_TimOverflow;
      r_ovf_s2 <= r_ovf_s1;
      r_pul_s1 <= i_TimOnePulse;
      r_pul_s2 <= r_pul_s1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_owner      <= '0;
      r_last       <= IDX_W'(N_REQ - 1);
      r_period     <= '0;
      r_mode       <= '0;
      r_div        <= '0;
      r_wdog       <= '0;
      r_pulse_seen <= 1'b0;
      r_done_flag  <= 1'b0;
      r_to_flag    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|i_Req) begin
            r_state  <= S_CLEAR;
            r_owner  <= w_win;
            r_period <= i_ReqPeriod[w_win*PERIOD_W +: PERIOD_W];
            r_mode   <= i_ReqMode[w_win*2 +: 2];
            r_div    <= i_ReqDivisor[w_win*2 +: 2];
          end
        end
        S_CLEAR: r_state <= S_ARM;
        S_ARM: begin
          r_state      <= S_RUN;
          r_wdog       <= '0;
          r_pulse_seen <= 1'b0;
          r_done_flag  <= 1'b0;
          r_to_flag    <= 1'b0;
        end
        S_RUN: begin
          r_wdog <= w_wdog_nxt;
          if ((r_mode == M_ONEPULS) && r_pul_s2) r_pulse_seen <= 1'b1;
          if (w_abort) begin
            r_state <= S_RELEASE;
          end else if (w_finish) begin
            r_state     <= S_RELEASE;
            r_done_flag <= 1'b1;
          end else if (w_wd_expire) begin
            r_state   <= S_RELEASE;
            r_to_flag <= 1'b1;
          end
        end
        S_RELEASE: begin
          r_last  <= r_owner;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so an async reset drops them at once.
  assign o_Busy          = (r_state != S_IDLE);
  assign o_Grant         = o_Busy ? w_owner_oh : '0;
  assign o_TimRst        = (r_state == S_CLEAR) || (r_state == S_RELEASE);
  assign o_TimEnable     = (r_state == S_ARM) || (r_state == S_RUN);
  assign o_Done          = ((r_state == S_RELEASE) && r_done_flag) ? w_owner_oh : '0;
  assign o_Timeout       = (r_state == S_RELEASE) && r_to_flag;
  assign o_TimPeriod     = r_period;
  assign o_TimMode       = r_mode;
  assign o_TimDivisor    = r_div;
  assign o_TimAutoReload = 1'b0;

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: behavioural Timer model, session scoreboard and a
// second small-watchdog instance for the timeout path.
module tb_timer_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req = '0;
  logic [127:0] req_period = '0;
  logic [7:0]   req_mode = '0;
  logic [7:0]   req_div = '0;
  logic [3:0]   grant, done;
  logic         timeout_o, busy, tim_en, tim_ar, tim_rst;
  logic [31:0]  tim_period;
  logic [1:0]   tim_mode, tim_div;
  logic         tim_ovf, tim_pul;

  logic [3:0]   wd_req = '0;
  logic [127:0] wd_period = '0;
  logic [7:0]   wd_mode = '0;
  logic [7:0]   wd_div = '0;
  logic [3:0]   wd_grant, wd_done;
  logic         wd_to, wd_busy, wd_en, wd_ar, wd_rst;
  logic [31:0]  wd_tper;
  logic [1:0]   wd_tmode, wd_tdiv;
  logic         wd_ovf = 1'b0;
  logic         wd_pul = 1'b0;

  always #5 clk = ~clk;

  timer_arbiter #(.N_REQ(4), .PERIOD_W(32), .TIMEOUT_W(24)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_Req(req), .i_ReqPeriod(req_period),
    .i_ReqMode(req_mode), .i_ReqDivisor(req_div), .o_Grant(grant), .o_Done(done),
    .o_Timeout(timeout_o), .o_Busy(busy), .o_TimPeriod(tim_period), .o_TimMode(tim_mode),
    .o_TimDivisor(tim_div), .o_TimEnable(tim_en), .o_TimAutoReload(tim_ar),
    .o_TimRst(tim_rst), .i_TimOverflow(tim_ovf), .i_TimOnePulse(tim_pul));

  timer_arbiter #(.N_REQ(4), .PERIOD_W(32), .TIMEOUT_W(4)) u_dut_wd (
    .i_clk(clk), .i_rst_n(rst_n), .i_Req(wd_req), .i_ReqPeriod(wd_period),
    .i_ReqMode(wd_mode), .i_ReqDivisor(wd_div), .o_Grant(wd_grant), .o_Done(wd_done),
    .o_Timeout(wd_to), .o_Busy(wd_busy), .o_TimPeriod(wd_tper), .o_TimMode(wd_tmode),
    .o_TimDivisor(wd_tdiv), .o_TimEnable(wd_en), .o_TimAutoReload(wd_ar),
    .o_TimRst(wd_rst), .i_TimOverflow(wd_ovf), .i_TimOnePulse(wd_pul));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Timer model: overflow after period+1 enabled clocks; one-pulse mode also
  // raises a 3-cycle pulse at that point.
  int m_cnt, m_pleft;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || tim_rst) begin
      m_cnt <= 0; m_pleft <= 0; tim_ovf <= 1'b0; tim_pul <= 1'b0;
    end else if (tim_en) begin
      if (!tim_ovf) begin
        if (m_cnt == int'(tim_period)) begin
          tim_ovf <= 1'b1;
          if (tim_mode == 2'b11) begin tim_pul <= 1'b1; m_pleft <= 3; end
        end else m_cnt <= m_cnt + 1;
      end else if (m_pleft != 0) begin
        m_pleft <= m_pleft - 1;
        if (m_pleft == 1) tim_pul <= 1'b0;
      end
    end
  end

  int cyc = 0;
  logic d1 = 1'b0, d2 = 1'b0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    d1  <= tim_pul;
    d2  <= d1;
  end

  typedef struct {
    int          owner;
    logic        done;
    logic [31:0] period;
    logic [1:0]  mode;
    logic [1:0]  div;
  } exp_t;
  exp_t sb[$];

  task automatic push_exp(input int o, input logic d, input logic [31:0] p,
                          input logic [1:0] m, input logic [1:0] dv);
    exp_t e;
    e.owner = o; e.done = d; e.period = p; e.mode = m; e.div = dv;
    sb.push_back(e);
  endtask

  task automatic set_cfg(input int k, input logic [31:0] p, input logic [1:0] m,
                         input logic [1:0] dv);
    req_period[k*32 +: 32] = p;
    req_mode[k*2 +: 2]     = m;
    req_div[k*2 +: 2]      = dv;
  endtask

  // Session monitor: a RELEASE is the cycle with grant, timer clear and enable
  // high on the previous cycle.
  int   n_rel = 0, rel_cyc = 0, fall_cyc = -100;
  logic prev_en = 1'b0, prev_d2 = 1'b0, op_seen = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (d2) op_seen = 1'b1;
      if (prev_d2 && !d2) fall_cyc = cyc;
      if (grant != 0 && tim_rst && prev_en) begin
        n_rel++;
        rel_cyc = cyc;
        if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'd1);
        else begin
          e = sb.pop_front();
          chk("rel_grant", 64'(grant), 64'(4'b1 << e.owner));
          chk("rel_done", 64'(done), e.done ? 64'(4'b1 << e.owner) : 64'd0);
          chk("rel_timeout", 64'(timeout_o), 64'd0);
          chk("rel_period", 64'(tim_period), 64'(e.period));
          chk("rel_mode_div", 64'({tim_mode, tim_div}), 64'({e.mode, e.div}));
          chk("rel_autoreload", 64'(tim_ar), 64'd0);
        end
      end else if (done != 0 || timeout_o) begin
        chk("spurious_done", 64'({done, timeout_o}), 64'd0);
      end
    end
    prev_en = tim_en;
    prev_d2 = d2;
  end

  task automatic wait_rel(input int target, input int limit, input string tag);
    int k = 0;
    while (n_rel < target && k < limit) begin
      @(negedge clk); #1;
      k++;
    end
    if (n_rel < target) chk(tag, 64'(n_rel), 64'(target));
  endtask

  task automatic wait_en(input int limit, input string tag);
    int k = 0;
    while (!tim_en && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (!tim_en) chk(tag, 64'(tim_en), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed cycle %0d expected completion", cyc);
    $fatal(1, "bench did not complete");
  end

  initial begin
    int base, k, low, en_cnt;

    // Reset state
    #1;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_busy_en_rst", 64'({busy, tim_en, tim_rst, timeout_o}), 64'd0);
    chk("rst_period_done", 64'({tim_period, done}), 64'd0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Round robin with all four requesting
    for (int i = 0; i < 4; i++) set_cfg(i, 32'd2, 2'b00, 2'b00);
    push_exp(0, 1'b1, 2, 0, 0); push_exp(1, 1'b1, 2, 0, 0);
    push_exp(2, 1'b1, 2, 0, 0); push_exp(3, 1'b1, 2, 0, 0);
    push_exp(0, 1'b1, 2, 0, 0);
    base = n_rel;
    #1 req = 4'b1111;
    wait_rel(base + 4, 300, "rr_wait4");
    req = 4'b0001;
    wait_rel(base + 5, 100, "rr_wait5");
    req = 4'b0000;
    repeat (3) @(negedge clk);

    // Single timer session with exact latency
    @(posedge clk); #1;
    set_cfg(0, 32'd10, 2'b00, 2'b00);
    push_exp(0, 1'b1, 10, 0, 0);
    req = 4'b0001;
    @(negedge clk);
    chk("t1_grant_t0", 64'(grant), 64'd0);
    @(negedge clk);
    chk("t1_grant_t1", 64'(grant), 64'b0001);
    chk("t1_rst_en_t1", 64'({tim_rst, tim_en}), 64'b10);
    @(negedge clk);
    chk("t1_rst_en_t2", 64'({tim_rst, tim_en}), 64'b01);
    k = 0;
    while (done == 0 && k < 40) begin @(negedge clk); k++; end
    chk("t1_done_latency", 64'(k), 64'd14);
    #1 req = 4'b0000;
    @(negedge clk);
    chk("t1_grant_after", 64'({grant, busy}), 64'd0);
    repeat (2) @(negedge clk);

    // One-pulse completion
    set_cfg(2, 32'd5, 2'b11, 2'b11);
    push_exp(2, 1'b1, 5, 2'b11, 2'b11);
    op_seen = 1'b0;
    base = n_rel;
    #1 req = 4'b0100;
    wait_rel(base + 1, 200, "op_wait");
    req = 4'b0000;
    chk("op_pulse_seen", 64'(op_seen), 64'd1);
    chk("op_release_cycle", 64'(rel_cyc), 64'(fall_cyc + 1));
    repeat (2) @(negedge clk);

    // Held PWM session with a mid-session period change
    set_cfg(1, 32'd7, 2'b10, 2'b01);
    push_exp(1, 1'b1, 7, 2'b10, 2'b01);
    base = n_rel;
    #1 req = 4'b0010;
    wait_en(20, "pwm_wait_en");
    low = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!tim_en) low++;
      if (i == 25) req_period[32 +: 32] = 32'd99;
    end
    #1 req = 4'b0000;
    wait_rel(base + 1, 20, "pwm_wait_rel");
    chk("pwm_enable_low_cycles", 64'(low), 64'd0);
    repeat (2) @(negedge clk);

    // Period zero completes immediately once flagged
    set_cfg(2, 32'd0, 2'b00, 2'b00);
    push_exp(2, 1'b1, 0, 0, 0);
    base = n_rel;
    #1 req = 4'b0100;
    wait_rel(base + 1, 50, "p0_wait");
    req = 4'b0000;
    repeat (2) @(negedge clk);

    // Mode-00 owner abort, then next requester
    set_cfg(3, 32'd1000, 2'b00, 2'b10);
    set_cfg(0, 32'd3, 2'b00, 2'b00);
    push_exp(3, 1'b0, 1000, 0, 2'b10);
    push_exp(0, 1'b1, 3, 0, 0);
    base = n_rel;
    #1 req = 4'b1001;
    repeat (20) @(negedge clk);
    #1 req = 4'b0001;
    wait_rel(base + 2, 100, "abort_wait");
    req = 4'b0000;
    repeat (2) @(negedge clk);

    // Async reset mid-RUN, then arbitration restarts at requester 0
    set_cfg(1, 32'd7, 2'b10, 2'b00);
    #1 req = 4'b0010;
    wait_en(20, "ar_wait_en");
    repeat (10) @(negedge clk);
    #1 req = 4'b0011;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_grant", 64'(grant), 64'd0);
    chk("ar_enable", 64'(tim_en), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    sb.delete();
    push_exp(0, 1'b1, 3, 0, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    base = n_rel;
    wait_rel(base + 1, 100, "ar_wait_rel");
    req = 4'b0000;
    repeat (2) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    // Watchdog with TIMEOUT_W=4 and no overflow
    #1 wd_req = 4'b0001;
    k = 0; en_cnt = 0;
    while (!wd_to && k < 100) begin
      @(negedge clk);
      if (wd_en) en_cnt++;
      k++;
    end
    chk("wd_timeout_seen", 64'(wd_to), 64'd1);
    chk("wd_run_cycles", 64'(en_cnt - 1), 64'd15);
    chk("wd_grant_done", 64'({wd_grant, wd_done}), 64'({4'b0001, 4'b0000}));
    #1 wd_req = 4'b0000;
    @(negedge clk);
    chk("wd_timeout_pulse", 64'({wd_to, wd_busy}), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
Shares one Timer instance between N_REQ requesters. Each session runs round-robin: grant, clear the timer, program period/mode/divisor, enable it, wait for completion, then release. Sits between software-facing requester ports and the Timer's configuration and status pins. Autoreload is never used. Every session starts from a cleared timer.

Parameters:
N_REQ, 4, number of requesters (2..8)
PERIOD_W, 32, timer period width
TIMEOUT_W, 24, width of the session watchdog counter; timeout fires at 2^TIMEOUT_W-1 cycles in RUN

Ports:
i_clk  in  1  system clock; also the Timer's source clock
i_rst_n  in  1  asynchronous active-low reset
i_Req  in  N_REQ  per-requester level request; held high for the whole session
i_ReqPeriod  in  N_REQ*PERIOD_W  packed periods; requester k at [k*PERIOD_W +: PERIOD_W]
i_ReqMode  in  N_REQ*2  packed modes: 00 timer, 01 counter, 10 PWM, 11 one-pulse
i_ReqDivisor  in  N_REQ*2  packed divisor codes: 00 /1, 01 /2, 10 /4, 11 /8
o_Grant  out  N_REQ  one-hot owner; all zero when idle
o_Done  out  N_REQ  one-cycle pulse to the owner on normal completion
o_Timeout  out  1  one-cycle pulse when a session is aborted by the watchdog
o_Busy  out  1  high in any state other than IDLE
o_TimPeriod  out  PERIOD_W  Timer period
o_TimMode  out  2  Timer mode
o_TimDivisor  out  2  Timer divisor
o_TimEnable  out  1  Timer enable
o_TimAutoReload  out  1  tied 0
o_TimRst  out  1  active-high Timer clear
i_TimOverflow  in  1  Timer overflow flag; sticky until o_TimRst
i_TimOnePulse  in  1  Timer one-pulse output

Behaviour:
- Reset (async, i_rst_n=0): state IDLE, all outputs 0, last-grant pointer = N_REQ-1, synchronizers cleared.
- i_TimOverflow and i_TimOnePulse pass through 2-flop synchronizers before use; this adds 2 cycles of detection latency.
- FSM states:
  - IDLE → CLEAR when any i_Req bit is high.
  - Winner: first requester with i_Req high, searching from last-grant+1 upward with wrap.
  - On that transition, latch the winner's period, mode and divisor into holding registers. o_Tim* outputs drive from these registers and stay stable for the whole session.
- CLEAR (1 cycle): o_Grant=winner, o_TimRst=1, o_TimEnable=0 → ARM.
- ARM (1 cycle): o_TimRst=0, o_TimEnable=1 → RUN. Clear the watchdog and the pulse-seen flag.
- RUN: o_TimEnable=1; watchdog increments each cycle. Completion conditions, in priority order:
  1. Owner's i_Req falls in mode 00/11: abort → RELEASE, no Done.
  2. Mode 00: synchronized overflow=1 → RELEASE with Done.
  3. Mode 11: set pulse-seen on synchronized pulse=1. Pulse-seen=1 and synchronized pulse=0 → RELEASE with Done.
  4. Mode 01/10: owner's i_Req falls → RELEASE with Done. This is a requester-held session.
  5. Watchdog reaches all-ones → RELEASE, o_Timeout pulse, no Done.
- RELEASE (1 cycle):
  - o_TimEnable=0, o_TimRst=1.
  - o_Done[owner] pulses if flagged; o_Grant still equals owner this cycle.
  - last-grant ← owner → IDLE; o_Grant=0 next cycle.
- Latency: request seen in IDLE at cycle t → o_Grant at t+1, o_TimEnable at t+2.
- Minimum gap between sessions: 1 IDLE cycle. Back-to-back requesters alternate strictly round-robin.
- Changes to a non-owner's request or config during a session are ignored. Changes to the owner's config after latch are ignored.
- Reset mid-session: immediate return to IDLE with all outputs 0, including o_TimEnable. The Timer relies on its own reset being asserted together with i_rst_n.
- A period of 0 is legal; the session completes as soon as the Timer flags it.

Test Plan:
1. Single timer session:
   - Stimulus: Req[0]=1, period=10, mode=00, div=00; model Timer overflows after 11 enabled clocks.
   - Required: Grant=0001 at t+1; TimRst pulse at t+1; Enable at t+2; Done[0] pulse ≈ t+2+11+2; Grant=0 next cycle.
2. Round-robin fairness:
   - Stimulus: Req=1111 held, every session mode 00, period=2.
   - Required: grants in order 0,1,2,3,0. Exactly one CLEAR/ARM/RUN/RELEASE sequence between grants.
3. One-pulse completion:
   - Stimulus: Req[2], mode=11, period=5, pulse length 3.
   - Required: Done[2] only after the synchronized pulse rises then falls; no Done while it is high.
4. Held PWM session:
   - Stimulus: Req[1], mode=10, drop Req[1] after 50 cycles.
   - Required: Enable high throughout; Done[1] pulse in RELEASE; the TimPeriod latch ignores a mid-session change of i_ReqPeriod[1].
5. Abort paths:
   - Stimulus A: mode-00 owner drops Req before overflow. Required: no Done, RELEASE, next requester granted.
   - Stimulus B: TIMEOUT_W=4, overflow never arrives. Required: o_Timeout pulse after 15 RUN cycles.
6. Async reset:
   - Stimulus: assert i_rst_n=0 mid-RUN between clock edges.
   - Required: Grant, Enable and Busy go 0 immediately; after release, arbitration restarts at requester 0.
